fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value after reset and after a program load.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port stall, input, 1: hazard stall request from decode.
REQ-005 SHALL have port branch_taken, input, 1: redirect request from execute.
REQ-006 SHALL have port branch_target, input, 32: redirect address.
REQ-007 SHALL have port ld_start, input, 1: one-cycle pulse that starts a program load.
REQ-008 SHALL have port ld_end, input, 1: one-cycle pulse that ends a program load.
REQ-009 SHALL have port ld_valid, input, 1: a load byte is present.
REQ-010 SHALL have port ld_data, input, 8: load byte.
REQ-011 SHALL have port ld_ready, output, 1: the block accepts the load byte this cycle.
REQ-012 SHALL have port pc, output, 32: fetch address to instruction memory.
REQ-013 SHALL have port pc_id, output, 32: PC of the instruction currently at the instruction-memory output.
REQ-014 SHALL have ports read_en, output, 1, and flush, output, 1: instruction-memory controls.
REQ-015 SHALL have ports write_en, output, 1; write_addr, output, 8; and write_data, output, 32: instruction-memory write port.
REQ-016 SHALL have port loading, output, 1: high while the FSM is in LOAD.

Function
REQ-017 SHALL implement FSM states RUN and LOAD.
REQ-018 SHALL transition RUN->LOAD on ld_start and LOAD->RUN on ld_end.
REQ-019 In RUN, SHALL apply priority ld_start > branch_taken > stall > advance.
REQ-020 On branch_taken in RUN, SHALL set pc <= {branch_target[31:2],2'b00} and drive flush=1 combinationally that same cycle.
REQ-021 On stall without branch_taken, SHALL hold pc and drive read_en=0, so the memory holds its output.
REQ-022 Otherwise in RUN, SHALL set pc <= pc+4 with 32-bit wrap (FFFF_FFFC -> 0000_0000) and drive read_en=1.
REQ-023 SHALL drive read_en and flush combinationally from state and inputs.
REQ-024 SHALL update pc_id to pc when read_en=1 and flush=0; SHALL set it to 0 when flush=1; SHALL hold it otherwise. This keeps pc_id aligned with the one-cycle memory latency.
REQ-025 In LOAD, SHALL drive read_en=0 and flush=1, and SHALL hold pc.
REQ-026 SHALL drive ld_ready = (state==LOAD) & ~ld_end; a byte transfers when ld_valid & ld_ready.
REQ-027 SHALL assemble bytes little-endian: the first byte is bits [7:0] and the fourth byte is bits [31:24].
REQ-028 The cycle after the 4th byte is accepted, SHALL pulse write_en for exactly one cycle with the assembled word, then increment write_addr modulo 256 (255 -> 0).
REQ-029 On ld_start, SHALL clear write_addr and the byte counter; ld_start while already in LOAD restarts the load at address 0.
REQ-030 On ld_end, SHALL discard any partial word, drop a byte presented in the same cycle, and set pc <= RESET_PC and pc_id <= 0 on entering RUN.
REQ-031 SHALL ignore branch_taken and stall in LOAD.

Reset
REQ-032 When rst=0 at a clock edge, SHALL set state=RUN, pc=RESET_PC, pc_id=0, write_addr=0, byte counter=0, write_en=0 and data register=0.
REQ-033 While in reset, SHALL drive read_en=0, flush=1, ld_ready=0 and loading=0.
REQ-034 Reset mid-load SHALL abort the load without issuing any further write.

Configuration
REQ-035 Macro FETCH_CTRL_LOADER_EN defined: the LOAD state and byte assembler SHALL be present as specified.
REQ-036 Macro FETCH_CTRL_LOADER_EN undefined: SHALL tie ld_ready, write_en and loading to 0 and write_addr and write_data to 0, SHALL ignore ld_start and ld_end, and the FSM SHALL remain in RUN.

Structure
REQ-037 Shared package SHALL hold the FSM state encoding (RUN, LOAD), the NOP constant 32'h0000_0000, the instruction-memory depth 256 and the address width 8.
REQ-038 The byte assembler SHALL be a sub-module named fetch_loader; the PC/FSM logic SHALL stay in fetch_ctrl.

Verification
REQ-039 Scenario: release reset with RESET_PC=0 and no stall. Required: pc reads 0,4,8,C on successive cycles; pc_id lags pc by one cycle; read_en=1.
REQ-040 Scenario: stall high for 2 cycles at pc=8. Required: pc holds 8 for both cycles, read_en=0, pc_id unchanged, then pc advances to C.
REQ-041 Scenario: branch_taken with target 0x0000_0043 and stall high in the same cycle. Required: flush=1 that cycle, next pc=0x40, next pc_id=0.
REQ-042 Scenario: ld_start, then bytes 13,00,50,00, then 93,00,10,00. Required: write_en pulses twice with addr 0 data 0x0050_0013 and addr 1 data 0x0010_0093.
REQ-043 Scenario: ld_end after 2 bytes of a third word, with ld_valid high that cycle. Required: no write, ld_ready=0, then RUN with pc=RESET_PC.
REQ-044 Scenario: 1028 bytes loaded. Required: write_addr wraps 255->0 and word 256 overwrites addr 0; a separate case asserts rst low mid-word and requires no write_en thereafter.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// fetch_ctrl_pkg : shared FSM encoding and instruction-memory constants
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } fetch_state_e;

  localparam logic [31:0] C_NOP        = 32'h0000_0000;
  localparam int unsigned C_IMEM_DEPTH = 256;
  localparam int unsigned C_IMEM_AW    = $clog2(C_IMEM_DEPTH);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_loader.sv
// ============================================================================
// fetch_loader : little-endian byte-to-word assembler for program loading.
// Present only when FETCH_CTRL_LOADER_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

`ifdef FETCH_CTRL_LOADER_EN
module fetch_loader
  import fetch_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_active,
  input  logic                 i_restart,
  input  logic                 i_abort,
  input  logic                 i_valid,
  input  logic [7:0]           i_data,
  output logic                 o_ready,
  output logic                 o_we,
  output logic [C_IMEM_AW-1:0] o_addr,
  output logic [31:0]          o_data
);

  logic [1:0]           r_cnt;
  logic                 r_we;
  logic [C_IMEM_AW-1:0] r_addr;
  logic [31:0]          r_data;
  logic                 w_accept;
  logic [1:0]           w_lane;

  assign o_ready  = i_active & ~i_abort;
  assign w_accept = o_ready & i_valid;
  // A restart re-bases the word, so a byte taken in that cycle becomes byte 0.
  assign w_lane   = i_restart ? 2'd0 : r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= 2'd0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= 32'h0000_0000;
    end else begin
      r_we <= w_accept & (r_cnt == 2'd3) & ~i_restart;
      if (i_restart) begin
        r_addr <= '0;
        r_cnt  <= {1'b0, w_accept};
      end else begin
        if (r_we) begin
          r_addr <= r_addr + 1'b1;
        end
        if (i_abort) begin
          r_cnt <= 2'd0;
        end else if (w_accept) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_accept) begin
        r_data[{w_lane, 3'b000} +: 8] <= i_data;
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule
`endif

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : PC sequencing with stall/branch handling and a RUN/LOAD FSM.
// Optional program loader enabled by FETCH_CTRL_LOADER_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 ld_start,
  input  logic                 ld_end,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  output logic                 ld_ready,
  output logic [31:0]          pc,
  output logic [31:0]          pc_id,
  output logic                 read_en,
  output logic                 flush,
  output logic                 write_en,
  output logic [C_IMEM_AW-1:0] write_addr,
  output logic [31:0]          write_data,
  output logic                 loading
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_pc_id;
  logic         w_read_en;
  logic         w_flush;
  logic         w_ld_start;
  logic         w_ld_end;
  logic         w_loading;

  assign w_loading = rst & (r_state == ST_LOAD);

`ifdef FETCH_CTRL_LOADER_EN
  assign w_ld_start = ld_start;
  assign w_ld_end   = ld_end;

  fetch_loader u_loader (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_loading),
    .i_restart (ld_start),
    .i_abort   (ld_end),
    .i_valid   (ld_valid),
    .i_data    (ld_data),
    .o_ready   (ld_ready),
    .o_we      (write_en),
    .o_addr    (write_addr),
    .o_data    (write_data)
  );
`else
  logic w_ld_unused;
  assign w_ld_unused = ^{ld_start, ld_end, ld_valid, ld_data};
  assign w_ld_start  = 1'b0;
  assign w_ld_end    = 1'b0;
  assign ld_ready    = 1'b0;
  assign write_en    = 1'b0;
  assign write_addr  = '0;
  assign write_data  = C_NOP;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_ld_start) w_state_nxt = ST_LOAD;
      ST_LOAD: if (w_ld_start) w_state_nxt = ST_LOAD;
               else if (w_ld_end) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Reset forces the memory into flush so nothing stale reaches decode.
  always_comb begin
    w_read_en = 1'b0;
    w_flush   = 1'b1;
    if (rst) begin
      case (r_state)
        ST_RUN: begin
          if (w_ld_start || branch_taken) begin
            w_read_en = 1'b0;
            w_flush   = 1'b1;
          end else if (stall) begin
            w_read_en = 1'b0;
            w_flush   = 1'b0;
          end else begin
            w_read_en = 1'b1;
            w_flush   = 1'b0;
          end
        end
        default: begin
          w_read_en = 1'b0;
          w_flush   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_pc_id <= C_NOP;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_ld_start) begin
            r_pc <= r_pc;
          end else if (branch_taken) begin
            r_pc <= word_align(branch_target);
          end else if (!stall) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        default: begin
          if (!w_ld_start && w_ld_end) begin
            r_pc <= RESET_PC;
          end
        end
      endcase
      // pc_id trails pc by the one-cycle memory read latency.
      if (w_flush) begin
        r_pc_id <= C_NOP;
      end else if (w_read_en) begin
        r_pc_id <= r_pc;
      end
    end
  end

  assign pc      = r_pc;
  assign pc_id   = r_pc_id;
  assign read_en = w_read_en;
  assign flush   = w_flush;
  assign loading = w_loading;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : directed self-checking bench for fetch_ctrl.
// Loader scenarios run when FETCH_CTRL_LOADER_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, ld_start, ld_end, ld_valid;
  logic [31:0] branch_target;
  logic [7:0]  ld_data;
  logic        ld_ready, read_en, flush, write_en, loading;
  logic [31:0] pc, pc_id, write_data;
  logic [7:0]  write_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .ld_start(ld_start), .ld_end(ld_end),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .pc(pc),
    .pc_id(pc_id), .read_en(read_en), .flush(flush), .write_en(write_en),
    .write_addr(write_addr), .write_data(write_data), .loading(loading)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    ld_start = 1'b0; ld_end = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", pc); end
    checks++; if (pc_id !== 32'h0) begin failures++; $display("FAIL rst_pc_id: got %h want 0", pc_id); end
    checks++; if (read_en !== 1'b0) begin failures++; $display("FAIL rst_read_en: got %b want 0", read_en); end
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rst_flush: got %b want 1", flush); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
    checks++; if (loading !== 1'b0) begin failures++; $display("FAIL rst_loading: got %b want 0", loading); end
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL rst_write_en: got %b want 0", write_en); end
    checks++; if (write_addr !== 8'h0) begin failures++; $display("FAIL rst_write_addr: got %h want 0", write_addr); end
  endtask

  task automatic test_sequential();
    rst = 1'b1;
    #1;
    checks++; if (read_en !== 1'b1) begin failures++; $display("FAIL seq_read_en: got %b want 1", read_en); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL seq_flush: got %b want 0", flush); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL seq_pc0: got %h want 0", pc); end
    tick();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL seq_pc1: got %h want 4", pc); end
    checks++; if (pc_id !== 32'h0) begin failures++; $display("FAIL seq_pc_id1: got %h want 0", pc_id); end
    tick();
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL seq_pc2: got %h want 8", pc); end
    checks++; if (pc_id !== 32'h4) begin failures++; $display("FAIL seq_pc_id2: got %h want 4", pc_id); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (read_en !== 1'b0) begin failures++; $display("FAIL stall_read_en: got %b want 0", read_en); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL stall_flush: got %b want 0", flush); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d]: got %h want 8", i, pc); end
      checks++; if (pc_id !== 32'h4) begin failures++; $display("FAIL stall_pc_id[%0d]: got %h want 4", i, pc_id); end
    end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'hC) begin failures++; $display("FAIL stall_release_pc: got %h want c", pc); end
    checks++; if (pc_id !== 32'h8) begin failures++; $display("FAIL stall_release_pc_id: got %h want 8", pc_id); end
    tick();
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL seq_pc4: got %h want 10", pc); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h0000_0043;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL br_flush: got %b want 1", flush); end
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL br_pc: got %h want 40", pc); end
    checks++; if (pc_id !== 32'h0) begin failures++; $display("FAIL br_pc_id: got %h want 0", pc_id); end
    tick();
    checks++; if (pc !== 32'h44) begin failures++; $display("FAIL br_next_pc: got %h want 44", pc); end
    checks++; if (pc_id !== 32'h40) begin failures++; $display("FAIL br_next_pc_id: got %h want 40", pc_id); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align_pc: got %h want fffffffc", pc); end
    tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want 0", pc); end
    checks++; if (pc_id !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc_id: got %h want fffffffc", pc_id); end
    tick();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL wrap_next_pc: got %h want 4", pc); end
  endtask

`ifdef FETCH_CTRL_LOADER_EN
  task automatic test_load();
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    #1;
    checks++; if (loading !== 1'b1) begin failures++; $display("FAIL ld_loading: got %b want 1", loading); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL ld_ready: got %b want 1", ld_ready); end
    checks++; if (read_en !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL ld_mem_ctl: got re=%b fl=%b want re=0 fl=1", read_en, flush); end
    branch_taken = 1'b1; branch_target = 32'h80; stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_data = prog[i];
      tick();
      if (i == 3) begin
        checks++; if (write_en !== 1'b1 || write_addr !== 8'h00 || write_data !== 32'h0050_0013) begin
          failures++; $display("FAIL ld_word0: got we=%b a=%h d=%h want we=1 a=00 d=00500013", write_en, write_addr, write_data); end
      end else if (i == 7) begin
        checks++; if (write_en !== 1'b1 || write_addr !== 8'h01 || write_data !== 32'h0010_0093) begin
          failures++; $display("FAIL ld_word1: got we=%b a=%h d=%h want we=1 a=01 d=00100093", write_en, write_addr, write_data); end
      end else begin
        checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL ld_idle_we[%0d]: got %b want 0", i, write_en); end
      end
    end
    ld_valid = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    tick();
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL ld_we_single: got %b want 0", write_en); end
    checks++; if (write_addr !== 8'h02) begin failures++; $display("FAIL ld_addr_inc: got %h want 02", write_addr); end
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL ld_pc_hold: got %h want 4", pc); end
    checks++; if (pc_id !== 32'h0) begin failures++; $display("FAIL ld_pc_id: got %h want 0", pc_id); end
  endtask

  task automatic test_load_end();
    ld_valid = 1'b1; ld_data = 8'hAA;
    tick();
    ld_data = 8'hBB;
    tick();
    ld_end = 1'b1; ld_data = 8'hCC;
    #1;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL end_ld_ready: got %b want 0", ld_ready); end
    tick();
    ld_end = 1'b0; ld_valid = 1'b0;
    checks++; if (loading !== 1'b0) begin failures++; $display("FAIL end_loading: got %b want 0", loading); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL end_pc: got %h want 0", pc); end
    checks++; if (pc_id !== 32'h0) begin failures++; $display("FAIL end_pc_id: got %h want 0", pc_id); end
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL end_we: got %b want 0", write_en); end
    checks++; if (read_en !== 1'b1) begin failures++; $display("FAIL end_read_en: got %b want 1", read_en); end
    tick();
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL end_we_late: got %b want 0", write_en); end
    checks++; if (write_addr !== 8'h02) begin failures++; $display("FAIL end_addr: got %h want 02", write_addr); end
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL end_run_pc: got %h want 4", pc); end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] exp_word;
    logic [7:0]  b;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int w = 0; w < 257; w++) begin
      exp_word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        b = 8'((w * 7) + (k * 61) + (w / 256) * 3);
        exp_word[k*8 +: 8] = b;
        ld_valid = 1'b1; ld_data = b;
        tick();
        if (k == 3) begin
          checks++; if (write_en !== 1'b1 || write_addr !== 8'(w) || write_data !== exp_word) begin
            failures++; $display("FAIL wrap_word[%0d]: got we=%b a=%h d=%h want we=1 a=%h d=%h", w, write_en, write_addr, write_data, 8'(w), exp_word); end
        end else if (k == 0 && w > 0) begin
          checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL wrap_we_pulse[%0d]: got %b want 0", w, write_en); end
        end
      end
    end
    ld_valid = 1'b0;
    tick();
    checks++; if (write_addr !== 8'h01) begin failures++; $display("FAIL wrap_addr_after: got %h want 01", write_addr); end
  endtask

  task automatic test_reset_midload();
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_data = 8'(8'h20 + k);
      tick();
    end
    rst = 1'b0; ld_data = 8'hFF;
    #1;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rml_ld_ready: got %b want 0", ld_ready); end
    checks++; if (loading !== 1'b0) begin failures++; $display("FAIL rml_loading: got %b want 0", loading); end
    checks++; if (read_en !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL rml_mem_ctl: got re=%b fl=%b want re=0 fl=1", read_en, flush); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL rml_we[%0d]: got %b want 0", i, write_en); end
    end
    ld_valid = 1'b0;
    checks++; if (write_addr !== 8'h00) begin failures++; $display("FAIL rml_addr: got %h want 00", write_addr); end
    checks++; if (pc !== 32'h18) begin failures++; $display("FAIL rml_pc: got %h want 18", pc); end
  endtask
`else
  task automatic test_noloader();
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h11;
    #1;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL nl_ld_ready: got %b want 0", ld_ready); end
    checks++; if (read_en !== 1'b1) begin failures++; $display("FAIL nl_read_en: got %b want 1", read_en); end
    tick();
    ld_start = 1'b0;
    checks++; if (loading !== 1'b0) begin failures++; $display("FAIL nl_loading: got %b want 0", loading); end
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL nl_pc: got %h want 8", pc); end
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL nl_we: got %b want 0", write_en); end
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0; ld_valid = 1'b0;
    checks++; if (pc !== 32'hC) begin failures++; $display("FAIL nl_end_pc: got %h want c", pc); end
    checks++; if (write_addr !== 8'h00 || write_data !== 32'h0) begin failures++; $display("FAIL nl_wport: got a=%h d=%h want 0", write_addr, write_data); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
`ifdef FETCH_CTRL_LOADER_EN
    test_load();
    test_load_end();
    test_addr_wrap();
    test_reset_midload();
`else
    test_noloader();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
